// File: rtl/spi_page_pkg.sv
// Shared state encoding, framing constants and byte helpers for the SPI page packer.
package spi_page_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HDR0 = 4'd1,
    ST_HDR1 = 4'd2,
    ST_PAY  = 4'd3,
    ST_TRL0 = 4'd4,
    ST_TRL1 = 4'd5,
    ST_TRL2 = 4'd6,
    ST_TRL3 = 4'd7,
    ST_PAD  = 4'd8
  } state_t;

  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
  localparam logic [7:0] TRL_MAGIC_DEF = 8'h5A;
  localparam logic [7:0] PAD_BYTE_DEF  = 8'h00;

  localparam int HDR_LEN = 2;
  localparam int TRL_LEN = 4;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] xsum_update(input logic [7:0] xsum, input logic [7:0] b);
    return xsum ^ b;
  endfunction

endpackage

// File: rtl/spi_page_packer.sv
// Frames 32-bit readout words into page-aligned byte packets (header, payload,
// length/XOR trailer, pad) for the downstream byte FIFO.
module spi_page_packer
  import spi_page_pkg::*;
#(
  parameter int         PAGE_BYTES = 256,
  parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEF,
  parameter logic [7:0] HDR_MAGIC  = HDR_MAGIC_DEF,
  parameter logic [7:0] TRL_MAGIC  = TRL_MAGIC_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        page_done,
  output logic        busy
);

  localparam int            PW       = $clog2(PAGE_BYTES);
  localparam logic [PW-1:0] PTR_LAST = PW'(PAGE_BYTES - 1);

  state_t        state_r;
  logic [31:0]   wbuf_r;
  logic          wlast_r;
  logic          wfull_r;
  logic          active_r;
  logic [1:0]    bidx_r;
  logic [PW-1:0] pptr_r;
  logic [7:0]    seq_r;
  logic [15:0]   len_r;
  logic [7:0]    xsum_r;
  logic          page_done_r;

  logic [7:0]    tdata_s;
  logic          tvalid_s;
  logic          s_tready_s;
  logic          s_hs_s;
  logic          m_hs_s;
  logic [7:0]    pay_byte_s;
  logic          pay_done_s;
  logic          page_wrap_s;

  // active_r keeps tready low while reset is held and for the release cycle
  assign s_tready_s  = active_r & ~wfull_r;
  assign s_hs_s      = s_axis_tvalid & s_tready_s;
  assign m_hs_s      = tvalid_s & m_axis_tready;
  assign pay_byte_s  = word_byte(wbuf_r, bidx_r);
  assign pay_done_s  = (state_r == ST_PAY) & m_hs_s & (bidx_r == 2'd3);
  assign page_wrap_s = m_hs_s & (pptr_r == PTR_LAST);

  assign s_axis_tready = s_tready_s;
  assign m_axis_tdata  = tdata_s;
  assign m_axis_tvalid = tvalid_s;
  assign page_done     = page_done_r;
  assign busy          = (state_r != ST_IDLE);

  // Output byte and valid selected from registered state
  always_comb begin
    tdata_s  = 8'h00;
    tvalid_s = 1'b1;
    case (state_r)
      ST_IDLE: begin
        tdata_s  = 8'h00;
        tvalid_s = 1'b0;
      end
      ST_HDR0: tdata_s = HDR_MAGIC;
      ST_HDR1: tdata_s = seq_r;
      ST_PAY: begin
        tdata_s  = pay_byte_s;
        tvalid_s = wfull_r;
      end
      ST_TRL0: tdata_s = TRL_MAGIC;
      ST_TRL1: tdata_s = len_r[7:0];
      ST_TRL2: tdata_s = len_r[15:8];
      ST_TRL3: tdata_s = xsum_r;
      ST_PAD:  tdata_s = PAD_BYTE;
      default: begin
        tdata_s  = 8'h00;
        tvalid_s = 1'b0;
      end
    endcase
  end

  // Single-word input buffer; refilled only after its last byte has gone out
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wbuf_r   <= 32'h0000_0000;
      wlast_r  <= 1'b0;
      wfull_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b1;
      if (s_hs_s) begin
        wbuf_r  <= s_axis_tdata;
        wlast_r <= s_axis_tlast;
        wfull_r <= 1'b1;
      end else if (pay_done_s) begin
        wfull_r <= 1'b0;
      end else begin
        wfull_r <= wfull_r;
      end
    end
  end

  // Framing FSM with page pointer, sequence, length and checksum
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      bidx_r      <= 2'd0;
      pptr_r      <= '0;
      seq_r       <= 8'h00;
      len_r       <= 16'h0000;
      xsum_r      <= 8'h00;
      page_done_r <= 1'b0;
    end else begin
      page_done_r <= page_wrap_s;
      if (m_hs_s) begin
        pptr_r <= pptr_r + PW'(1);
      end else begin
        pptr_r <= pptr_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (wfull_r) state_r <= ST_HDR0;
          else         state_r <= ST_IDLE;
        end
        ST_HDR0: begin
          if (m_hs_s) state_r <= ST_HDR1;
          else        state_r <= ST_HDR0;
        end
        ST_HDR1: begin
          if (m_hs_s) begin
            state_r <= ST_PAY;
            bidx_r  <= 2'd0;
          end else begin
            state_r <= ST_HDR1;
          end
        end
        ST_PAY: begin
          if (m_hs_s) begin
            bidx_r <= bidx_r + 2'd1;
            len_r  <= len_r + 16'd1;
            xsum_r <= xsum_update(xsum_r, pay_byte_s);
            if ((bidx_r == 2'd3) && wlast_r) state_r <= ST_TRL0;
            else                             state_r <= ST_PAY;
          end else begin
            state_r <= ST_PAY;
          end
        end
        ST_TRL0: begin
          if (m_hs_s) state_r <= ST_TRL1;
          else        state_r <= ST_TRL0;
        end
        ST_TRL1: begin
          if (m_hs_s) state_r <= ST_TRL2;
          else        state_r <= ST_TRL1;
        end
        ST_TRL2: begin
          if (m_hs_s) state_r <= ST_TRL3;
          else        state_r <= ST_TRL2;
        end
        ST_TRL3: begin
          if (page_wrap_s) begin
            state_r <= ST_IDLE;
            seq_r   <= seq_r + 8'd1;
            len_r   <= 16'h0000;
            xsum_r  <= 8'h00;
          end else if (m_hs_s) begin
            state_r <= ST_PAD;
          end else begin
            state_r <= ST_TRL3;
          end
        end
        ST_PAD: begin
          if (page_wrap_s) begin
            state_r <= ST_IDLE;
            seq_r   <= seq_r + 8'd1;
            len_r   <= 16'h0000;
            xsum_r  <= 8'h00;
          end else begin
            state_r <= ST_PAD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          bidx_r  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_page_packer.sv
// Randomized self-checking bench for spi_page_packer against a byte-stream model.
`timescale 1ns/1ps
module tb_spi_page_packer;
  import spi_page_pkg::*;

  localparam int PAGE = 256;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        page_done;
  logic        busy;

  spi_page_packer #(.PAGE_BYTES(PAGE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .page_done(page_done), .busy(busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  out_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] pkt_w[$];
  int          pd_cnt, pd_at, stall_err, bubble_cnt, drv_to;
  bit          rand_rdy = 1'b0;
  bit          abort    = 1'b0;
  logic [7:0]  model_seq = 8'h00;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Byte collector, stall-stability and page_done observer
  initial begin : monitor
    bit         stall_pend;
    logic [7:0] stall_data;
    stall_pend = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend && !(m_axis_tvalid === 1'b1 && m_axis_tdata === stall_data)) stall_err++;
        if (page_done === 1'b1) begin pd_cnt++; pd_at = out_q.size(); end
        if (busy === 1'b1 && m_axis_tvalid === 1'b0) bubble_cnt++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) out_q.push_back(m_axis_tdata);
        stall_pend = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
        stall_data = m_axis_tdata;
      end
    end
  end

  task automatic clear_obs();
    out_q.delete(); exp_q.delete();
    pd_cnt = 0; pd_at = -1; stall_err = 0; bubble_cnt = 0; drv_to = 0;
  endtask

  task automatic make_pkt(input int n);
    pkt_w.delete();
    repeat (n) pkt_w.push_back($urandom);
  endtask

  // Expected framed bytes of the packet in pkt_w, built from the framing rules
  task automatic model_pkt();
    logic [15:0] len = 16'd0;
    logic [7:0]  x   = 8'h00;
    logic [31:0] w;
    int          total;
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_seq);
    foreach (pkt_w[i]) begin
      for (int b = 0; b < 4; b++) begin
        w = pkt_w[i] >> (8 * b);
        exp_q.push_back(w[7:0]);
        x = x ^ w[7:0];
        len = len + 16'd1;
      end
    end
    exp_q.push_back(8'h5A);
    exp_q.push_back(len[7:0]);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(x);
    total = HDR_LEN + 4 * pkt_w.size() + TRL_LEN;
    while (total % PAGE != 0) begin exp_q.push_back(8'h00); total++; end
    model_seq = model_seq + 8'd1;
  endtask

  // Drives pkt_w on s_axis; called and returns at posedge+1
  task automatic send_pkt(input int gap);
    int n;
    int to;
    bit hs;
    n = pkt_w.size();
    for (int i = 0; i < n; i++) begin
      if (abort) return;
      s_axis_tdata  = pkt_w[i];
      s_axis_tlast  = (i == n - 1);
      s_axis_tvalid = 1'b1;
      to = 0;
      hs = 1'b0;
      do begin
        @(negedge aclk); hs = (s_axis_tready === 1'b1);
        @(posedge aclk); #1; to++;
      end while (!hs && to < 2000 && !abort);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (abort) return;
      if (!hs) drv_to++;
      repeat (gap) begin @(posedge aclk); #1; end
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int c = 0;
    while (out_q.size() < n && c < n * 4 + 2000) begin @(posedge aclk); #1; c++; end
    ok = (out_q.size() >= n);
    repeat (8) begin @(posedge aclk); #1; end
  endtask

  function automatic int first_diff();
    int n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    #11;
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    n_tests++; if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got %h want 00", m_axis_tdata); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (page_done !== 1'b0) begin n_fail++; $display("FAIL reset_page_done got %b want 0", page_done); end
    n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready_low got %b want 0", s_axis_tready); end
    #10 aresetn = 1'b1;
    @(posedge aclk); #1;
    n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready_high got %b want 1", s_axis_tready); end
  endtask

  task automatic test_single_word();
    bit         ok;
    int         d;
    logic [7:0] lit [0:9];
    lit = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h04, 8'h00, 8'h44};
    clear_obs();
    pkt_w.delete(); pkt_w.push_back(32'h44332211);
    model_pkt();
    send_pkt(0);
    wait_bytes(PAGE, ok);
    n_tests++; if (!ok || drv_to != 0) begin n_fail++; $display("FAIL single_timeout got %0d bytes want %0d", out_q.size(), PAGE); end
    n_tests++; if (out_q.size() != PAGE) begin n_fail++; $display("FAIL single_len got %0d want %0d", out_q.size(), PAGE); end
    d = -1;
    for (int i = 0; i < 10 && i < out_q.size(); i++) if (d < 0 && out_q[i] !== lit[i]) d = i;
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL single_frame byte %0d got %h want %h", d, out_q[d], lit[d]); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL single_stream byte %0d got %h want %h", d, out_q[d], exp_q[d]); end
    n_tests++; if (pd_cnt != 1) begin n_fail++; $display("FAIL single_page_done got %0d pulses want 1", pd_cnt); end
    n_tests++; if (pd_at != PAGE) begin n_fail++; $display("FAIL single_page_done_timing got %0d want %0d", pd_at, PAGE); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", busy); end
  endtask

  task automatic test_page_boundary();
    bit ok;
    int d;
    clear_obs();
    make_pkt(62); model_pkt(); send_pkt(0);
    wait_bytes(PAGE, ok);
    d = first_diff();
    n_tests++; if (!ok || out_q.size() != PAGE || d >= 0) begin n_fail++; $display("FAIL w62_stream got %0d bytes diff@%0d want %0d bytes", out_q.size(), d, PAGE); end
    n_tests++; if (pd_cnt != 1) begin n_fail++; $display("FAIL w62_page_done got %0d want 1", pd_cnt); end
    clear_obs();
    make_pkt(63); model_pkt(); send_pkt(0);
    wait_bytes(2 * PAGE, ok);
    d = first_diff();
    n_tests++; if (!ok || out_q.size() != 2 * PAGE || d >= 0) begin n_fail++; $display("FAIL w63_stream got %0d bytes diff@%0d want %0d bytes", out_q.size(), d, 2 * PAGE); end
    n_tests++; if (pd_cnt != 2) begin n_fail++; $display("FAIL w63_page_done got %0d want 2", pd_cnt); end
    n_tests++;
    if (out_q.size() < 257 || out_q[255] !== 8'hFC || out_q[256] !== 8'h00) begin
      n_fail++; $display("FAIL w63_len got %h%h want 00fc", (out_q.size() > 256) ? out_q[256] : 8'hxx, (out_q.size() > 255) ? out_q[255] : 8'hxx);
    end
    n_tests++; if (drv_to != 0) begin n_fail++; $display("FAIL boundary_driver got %0d timeouts want 0", drv_to); end
  endtask

  task automatic test_stall();
    bit ok;
    int d;
    clear_obs();
    make_pkt(10); model_pkt();
    rand_rdy = 1'b1;
    send_pkt(0);
    wait_bytes(PAGE, ok);
    rand_rdy = 1'b0;
    d = first_diff();
    n_tests++; if (!ok || drv_to != 0) begin n_fail++; $display("FAIL stall_timeout got %0d bytes want %0d", out_q.size(), PAGE); end
    n_tests++; if (out_q.size() != PAGE || d >= 0) begin n_fail++; $display("FAIL stall_stream got %0d bytes diff@%0d want %0d bytes", out_q.size(), d, PAGE); end
    n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_err); end
  endtask

  task automatic test_gaps();
    bit ok;
    int d;
    clear_obs();
    make_pkt(8); model_pkt();
    send_pkt(3);
    wait_bytes(PAGE, ok);
    d = first_diff();
    n_tests++; if (!ok || out_q.size() != PAGE || d >= 0 || drv_to != 0) begin n_fail++; $display("FAIL gaps_stream got %0d bytes diff@%0d want %0d bytes", out_q.size(), d, PAGE); end
    n_tests++; if (bubble_cnt < 7) begin n_fail++; $display("FAIL gaps_bubbles got %0d want >=7", bubble_cnt); end
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         d;
    int         k_ff;
    logic [7:0] seq0;
    logic [7:0] seq1;
    clear_obs();
    seq0 = model_seq;
    seq1 = seq0 + 8'd1;
    k_ff = 255 - int'(seq0);
    for (int p = 0; p < 257; p++) begin
      make_pkt(1); model_pkt(); send_pkt(0);
    end
    wait_bytes(257 * PAGE, ok);
    d = first_diff();
    n_tests++; if (!ok || drv_to != 0) begin n_fail++; $display("FAIL b2b_timeout got %0d bytes want %0d", out_q.size(), 257 * PAGE); end
    n_tests++; if (out_q.size() != 257 * PAGE || d >= 0) begin n_fail++; $display("FAIL b2b_stream got %0d bytes diff@%0d want %0d bytes", out_q.size(), d, 257 * PAGE); end
    n_tests++;
    if (out_q.size() < 2 * PAGE || out_q[PAGE] !== 8'hA5 || out_q[PAGE + 1] !== seq1) begin
      n_fail++; $display("FAIL b2b_second_header got size %0d want A5 %h at byte %0d", out_q.size(), seq1, PAGE);
    end
    n_tests++;
    if (out_q.size() < (k_ff + 2) * PAGE || out_q[k_ff * PAGE + 1] !== 8'hFF || out_q[(k_ff + 1) * PAGE + 1] !== 8'h00) begin
      n_fail++; $display("FAIL b2b_seq_wrap got size %0d want FF then 00 at pages %0d/%0d", out_q.size(), k_ff, k_ff + 1);
    end
    n_tests++; if (pd_cnt != 257) begin n_fail++; $display("FAIL b2b_page_done got %0d want 257", pd_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    int c;
    clear_obs();
    make_pkt(8);
    abort = 1'b0;
    fork
      send_pkt(0);
      begin
        c = 0;
        while (out_q.size() < 20 && c < 500) begin @(posedge aclk); #1; c++; end
        n_tests++; if (out_q.size() < 20) begin n_fail++; $display("FAIL rmid_reach got %0d bytes want 20", out_q.size()); end
        #2 aresetn = 1'b0;
        #1;
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid got %b want 0", m_axis_tvalid); end
        n_tests++; if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_tready got %b/%b want 0/0", busy, s_axis_tready); end
        abort = 1'b1;
      end
    join
    repeat (3) begin @(posedge aclk); #1; end
    aresetn = 1'b1;
    abort = 1'b0;
    @(posedge aclk); #1;
    repeat (4) begin @(posedge aclk); #1; end
    clear_obs();
    model_seq = 8'h00;
    make_pkt(1); model_pkt(); send_pkt(0);
    wait_bytes(PAGE, ok);
    d = first_diff();
    n_tests++; if (!ok || out_q.size() != PAGE || d >= 0) begin n_fail++; $display("FAIL rmid_restart got %0d bytes diff@%0d want %0d bytes", out_q.size(), d, PAGE); end
    n_tests++; if (pd_cnt != 1 || pd_at != PAGE) begin n_fail++; $display("FAIL rmid_pptr got %0d pulses at %0d want 1 at %0d", pd_cnt, pd_at, PAGE); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_page_boundary();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
